serial_twos_comp: RTL and testbench
===================================

# serial_twos_comp

Bit-serial, LSB-first two's-complement negator for fixed-length words of WIDTH bits. It is a Mealy state machine: it passes bits through unchanged up to and including the first 1, then inverts every later bit of the word. It sits in the serial arithmetic path beside the bit-serial one's-complement inverter, turning an inverted stream into a true negation. Framing is done by an internal bit counter, and the outputs are registered.

## Interface
- WIDTH, 8, number of bits per word (≥2)
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_bit is a valid stream bit this cycle
- in_bit  input  1  serial data, LSB first
- out_valid  output  1  out_bit is valid; registered
- out_bit  output  1  negated serial data, LSB first; registered
- out_last  output  1  out_bit is the MSB (last bit) of a word
- out_ovf  output  1  asserted with out_last when the input word was the most-negative value (1 followed by WIDTH-1 zeros, MSB-first)

## Operation
- States: PASS (no 1 seen yet in the current word) and INV (a 1 has been seen). Reset state is PASS.
- Bit counter cnt has width $clog2(WIDTH) and resets to 0. It increments only on in_valid. When it reaches WIDTH-1 with in_valid, it wraps to 0.
- When in_valid=1 in PASS:
  - result bit = in_bit.
  - If in_bit=1, next state is INV; otherwise it stays PASS.
- When in_valid=1 in INV:
  - result bit = ~in_bit; the state stays INV.
- End of word (in_valid=1 and cnt==WIDTH-1):
  - After producing the result bit, the next state is forced to PASS, overriding any transition above.
  - The result is tagged last.
- Overflow: on the last bit, ovf = (state==PASS) & in_bit. Only the most-negative input reaches its MSB still in PASS with a 1.
- All-zero word: the output is all zeros, the state stays PASS, and ovf=0.
- in_valid=0 holds the state and cnt. Gaps of any length are allowed both inside a word and between words.
- There is no backpressure. A downstream sink must accept one bit per cycle.

## Timing
- Latency: 1 cycle. A bit sampled with in_valid at edge N appears on out_* after edge N.
- out_valid(N+1) = in_valid(N). When out_valid=0, out_bit, out_last and out_ovf are driven 0.
- Back-to-back words: the bit after the MSB starts a new word in PASS with no idle cycle.
- Reset values: out_valid=0, out_bit=0, out_last=0, out_ovf=0, state=PASS, cnt=0.
- Reset asserted mid-word:
  - The partial word is discarded and no out_last is produced for it.
  - The first valid bit after rst deasserts is bit 0 of a new word.
- out_ovf is only ever high together with out_last.

## Configuration
- SERIAL_TWOS_COMP_OVF_EN defined: the overflow logic is compiled in and out_ovf behaves as above.
- SERIAL_TWOS_COMP_OVF_EN undefined: the overflow logic is removed, and out_ovf remains as a port tied to constant 0.

## Structure
- Shared package serial_pkg holds:
  - the state typedef {PASS, INV} (1-bit encoding);
  - the default word width constant SERIAL_WIDTH=8, which also serves as the WIDTH default.
- One sub-module, serial_bit_cnt:
  - parameter WIDTH; inputs clk, rst, en;
  - outputs cnt and last (= en & cnt==WIDTH-1);
  - wraps to 0 after WIDTH-1.
- The FSM, result logic and output registers live in serial_twos_comp.

## Test plan
- WIDTH=8, continuous valid:
  - 0x06 (bits in: 0,1,1,0,0,0,0,0) → bits out 0,1,0,1,1,1,1,1 (0xFA).
  - out_last on the 8th output; out_ovf=0.
- 0x00 → 0x00, out_ovf=0; 0x01 → 0xFF, out_ovf=0.
- 0x80 → 0x80 with out_ovf=1 on the MSB. Without SERIAL_TWOS_COMP_OVF_EN, out_ovf stays 0.
- 0x06 sent with random in_valid gaps, immediately followed by 0x7F:
  - outputs 0xFA then 0x81;
  - exactly two out_last pulses;
  - out_valid mirrors in_valid delayed by one cycle.
- Reset pulse after 3 bits of 0x0C, then 0x03 sent:
  - all outputs are 0 during reset;
  - the next word yields 0xFD with out_last on its 8th bit.
- Stream 256 words covering all 8-bit values. Each output must equal (−x) mod 256, and out_ovf must be high only for x=0x80.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial arithmetic path.
// Holds the negator state encoding and the default word width.
package serial_pkg;

   localparam int SERIAL_WIDTH = 8;

   typedef enum logic {
      PASS = 1'b0,
      INV  = 1'b1
   } state_t;

endpackage

// File: rtl/serial_twos_comp_if.sv
// Serial stream bundle between a bit source and the two's-complement negator.
// The master drives input bits; the slave (the negator) returns the result stream.
interface serial_twos_comp_if;

   logic in_valid;
   logic in_bit;
   logic out_valid;
   logic out_bit;
   logic out_last;
   logic out_ovf;

   modport master (
      output in_valid, in_bit,
      input  out_valid, out_bit, out_last, out_ovf
   );

   modport slave (
      input  in_valid, in_bit,
      output out_valid, out_bit, out_last, out_ovf
   );

endinterface

// File: rtl/serial_bit_cnt.sv
// Word framing counter: advances on each enabled bit and wraps after WIDTH-1.
// last flags the enabled cycle that carries the final bit of a word.
module serial_bit_cnt
   import serial_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   assign last = en && (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= last ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/serial_twos_comp.sv
// Bit-serial LSB-first two's-complement negator with registered outputs.
// Define SERIAL_TWOS_COMP_OVF_EN to build the most-negative overflow flag; otherwise out_ovf is tied 0.
module serial_twos_comp
   import serial_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   serial_twos_comp_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           state;
   state_t           state_next;
   logic             res_bit;
   logic             word_end;
   logic [CNT_W-1:0] bit_cnt;
   logic             bit_cnt_unused;

   serial_bit_cnt #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.in_valid),
      .cnt  (bit_cnt),
      .last (word_end)
   );

   assign bit_cnt_unused = ^bit_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= PASS;
      end else begin
         state <= state_next;
      end
   end

   // Copy bits until the first 1 has gone through, then invert; every word starts fresh in PASS.
   always_comb begin
      state_next = state;
      res_bit    = 1'b0;
      if (bus.in_valid) begin
         case (state)
            PASS: begin
               res_bit = bus.in_bit;
               if (bus.in_bit) begin
                  state_next = INV;
               end
            end
            INV: begin
               res_bit = ~bus.in_bit;
            end
            default: begin
               res_bit    = 1'b0;
               state_next = PASS;
            end
         endcase
         if (word_end) begin
            state_next = PASS;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_valid <= 1'b0;
         bus.out_bit   <= 1'b0;
         bus.out_last  <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         bus.out_bit   <= res_bit;
         bus.out_last  <= word_end;
      end
   end

`ifdef SERIAL_TWOS_COMP_OVF_EN
   // Only the most-negative word reaches its MSB with no earlier 1 and a 1 in the MSB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_ovf <= 1'b0;
      end else begin
         bus.out_ovf <= word_end && (state == PASS) && bus.in_bit;
      end
   end
`else
   assign bus.out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_twos_comp.sv
// Self-checking bench for serial_twos_comp: constant vector table, multi-cycle corner sequences,
// and an exhaustive randomized-gap stream checked against word-level arithmetic negation.
module tb_serial_twos_comp;
   import serial_pkg::*;

`ifdef SERIAL_TWOS_COMP_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      bit         ovf;
   } vec_t;

   typedef struct {
      logic [7:0] y;
      logic       ovf;
   } word_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   last_count;
   logic exp_valid;
   logic [7:0] acc;
   logic [2:0] acc_idx;
   word_t out_q[$];

   serial_twos_comp_if bus ();

   serial_twos_comp #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // out_valid must mirror in_valid one edge later; reset clears it.
   always @(posedge clk) exp_valid <= rst ? bus.in_valid : 1'b0;

   // Word collector plus per-cycle protocol checks.
   always @(negedge clk) begin
      check("out_valid_mirror", {31'd0, bus.out_valid}, {31'd0, (rst ? exp_valid : 1'b0)});
      if (!bus.out_valid) begin
         check("idle_out_bit", {31'd0, bus.out_bit}, 32'd0);
         check("idle_out_last", {31'd0, bus.out_last}, 32'd0);
      end
      if (bus.out_ovf) check("ovf_needs_last", {31'd0, bus.out_last}, 32'd1);
      if (!rst) begin
         acc_idx = 3'd0;
      end else if (bus.out_valid) begin
         acc[acc_idx] = bus.out_bit;
         acc_idx      = acc_idx + 3'd1;
         if (bus.out_last) begin
            out_q.push_back('{y: acc, ovf: bus.out_ovf});
            last_count++;
            acc_idx = 3'd0;
         end
      end
   end

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b, input int max_gap);
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (gap > 0) idle(gap);
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [7:0] x, input int max_gap);
      for (int i = 0; i < 8; i++) send_bit(x[i], max_gap);
   endtask

   task automatic check_output(input string name, input logic [7:0] exp_y, input bit exp_ovf);
      word_t w;
      int budget;
      budget = 0;
      while (out_q.size() == 0 && budget < 12) begin
         @(negedge clk);
         #1;
         budget++;
      end
      if (out_q.size() == 0) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         w = out_q.pop_front();
         check({name, "_word"}, {24'd0, w.y}, {24'd0, exp_y});
         check({name, "_ovf"}, {31'd0, w.ovf}, {31'd0, exp_ovf});
      end
   endtask

   vec_t vecs[5];
   int   lc0;
   logic [7:0] rx;

   initial begin
      checks = 0;
      errors = 0;
      last_count = 0;
      acc = '0;
      acc_idx = '0;
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;

      vecs[0] = '{x: 8'h06, y: 8'hFA, ovf: 1'b0};
      vecs[1] = '{x: 8'h00, y: 8'h00, ovf: 1'b0};
      vecs[2] = '{x: 8'h01, y: 8'hFF, ovf: 1'b0};
      vecs[3] = '{x: 8'h80, y: 8'h80, ovf: OVF_EN};
      vecs[4] = '{x: 8'h7F, y: 8'h81, ovf: 1'b0};

      rst = 1'b0;
      #1;
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_out_bit", {31'd0, bus.out_bit}, 32'd0);
      check("reset_out_last", {31'd0, bus.out_last}, 32'd0);
      check("reset_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1);

      // Continuous-valid table, including the 8th-bit out_last check.
      for (int i = 0; i < 5; i++) begin
         lc0 = last_count;
         apply_stimulus(vecs[i].x, 0);
         check_output($sformatf("table%0d", i), vecs[i].y, vecs[i].ovf);
         check($sformatf("table%0d_lasts", i), last_count - lc0, 32'd1);
      end
      idle(2);

      // Gapped 0x06 immediately followed by 0x7F.
      lc0 = last_count;
      apply_stimulus(8'h06, 3);
      apply_stimulus(8'h7F, 3);
      idle(3);
      check_output("gap_first", 8'hFA, 1'b0);
      check_output("gap_second", 8'h81, 1'b0);
      check("gap_lasts", last_count - lc0, 32'd2);

      // Reset in the middle of 0x0C, then 0x03.
      lc0 = last_count;
      for (int i = 0; i < 3; i++) send_bit(1'(8'h0C >> i), 0);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_out_bit", {31'd0, bus.out_bit}, 32'd0);
      check("midrst_out_last", {31'd0, bus.out_last}, 32'd0);
      check("midrst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1);
      apply_stimulus(8'h03, 0);
      check_output("after_rst", 8'hFD, 1'b0);
      check("after_rst_lasts", last_count - lc0, 32'd1);
      check("after_rst_queue_empty", out_q.size(), 32'd0);

      // Exhaustive stream with random gaps, reference = arithmetic negation mod 256.
      for (int x = 0; x < 256; x++) begin
         apply_stimulus(8'(x), ($urandom_range(0, 3) == 0) ? 2 : 0);
         check_output($sformatf("all_%02h", x), 8'(256 - x), OVF_EN && (x == 128));
      end
      idle(2);

      // Random words in random order with gaps.
      for (int k = 0; k < 40; k++) begin
         rx = 8'($urandom);
         apply_stimulus(rx, 1);
         check_output($sformatf("rand%0d", k), 8'(256 - int'(rx)), OVF_EN && (rx == 8'h80));
      end
      idle(3);
      check("final_queue_empty", out_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
